// File: rtl/unified_memory_if.sv
// Request/response bundle for the shared instruction-fetch and data channels
// of unified_memory. The requester holds master, the memory holds slave.
interface unified_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/unified_memory.sv
// Single-ported word array shared by a fetch channel and a data channel,
// arbitrated round-robin through a three-state IDLE/WAIT/RESP sequencer.
module unified_memory #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    unified_memory_if.slave     bus,
    output logic                busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;
    localparam logic [2:0] LAT_M1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_fetch_q;
    logic              chan_q;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic              gnt_f, gnt_d, gnt_any, enter_resp;
    logic [IDX_W-1:0]  in_idx, acc_idx;
    logic              in_we, acc_we, acc_fetch;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wdata;

    // Grant only from IDLE and never while reset is held; ties go to the
    // channel that lost last time.
    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        if (state_q == S_IDLE && reset) begin
            if (bus.d_req && (!bus.if_req || last_fetch_q))
                gnt_d = 1'b1;
            else if (bus.if_req)
                gnt_f = 1'b1;
        end
    end

    assign gnt_any = gnt_f | gnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    if (LATENCY == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero latency the array is accessed on the grant edge itself, so
    // the live request fields are used instead of the latched copies.
    assign in_idx    = gnt_f ? bus.if_addr[IDX_W+1:2] : bus.d_addr[IDX_W+1:2];
    assign in_we     = gnt_d & bus.d_we;
    assign acc_idx   = (state_q == S_IDLE) ? in_idx      : idx_q;
    assign acc_we    = (state_q == S_IDLE) ? in_we       : we_q;
    assign acc_be    = (state_q == S_IDLE) ? bus.d_be    : be_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.d_wdata : wdata_q;
    assign acc_fetch = (state_q == S_IDLE) ? gnt_f       : chan_q;

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            idx_q   <= in_idx;
            we_q    <= in_we;
            be_q    <= bus.d_be;
            wdata_q <= bus.d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && acc_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be[b])
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_fetch_q <= 1'b1;
            chan_q       <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt_any) begin
                last_fetch_q <= gnt_f;
                chan_q       <= gnt_f;
            end
            if (enter_resp && !acc_we) begin
                if (acc_fetch)
                    if_rdata_q <= mem_q[acc_idx];
                else
                    d_rdata_q  <= mem_q[acc_idx];
            end
        end
    end

    assign bus.if_gnt    = gnt_f;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = (state_q == S_RESP) &&  chan_q;
    assign bus.d_rvalid  = (state_q == S_RESP) && !chan_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_unified_memory.sv
// Directed bench for unified_memory: one instance at LATENCY=1 for the main
// function and arbitration, one at LATENCY=0 for the short-path timing.
module tb_unified_memory;
    logic clk;
    logic reset;
    logic busy_a, busy_b;
    int   checks;
    int   errors;

    unified_memory_if #(.DATA_W(32), .ADDR_W(32)) ua ();
    unified_memory_if #(.DATA_W(32), .ADDR_W(32)) ub ();

    unified_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ua), .busy(busy_a)
    );
    unified_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ub), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One transaction on instance A; lat counts cycles from grant to rvalid
    // (-1 when the grant or the response never arrives).
    task automatic xfer(input bit fetch, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        bit granted;
        granted = 1'b0;
        lat     = -1;
        rd      = 'x;
        @(posedge clk); #1;
        if (fetch) begin
            ua.if_req = 1'b1; ua.if_addr = addr;
        end else begin
            ua.d_req = 1'b1; ua.d_we = we; ua.d_be = be; ua.d_addr = addr; ua.d_wdata = wd;
        end
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            granted = fetch ? ua.if_gnt : ua.d_gnt;
        end
        @(posedge clk); #1;
        ua.if_req = 1'b0; ua.d_req = 1'b0;
        ua.if_addr = ~addr; ua.d_addr = ~addr; ua.d_wdata = ~wd; ua.d_be = ~be; ua.d_we = ~we;
        if (granted) begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (fetch ? ua.if_rvalid : ua.d_rvalid) begin
                    lat = i;
                    rd  = fetch ? ua.if_rdata : ua.d_rdata;
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          gcyc [3];
        bit          gch  [3];
        int          ng;
        bit          gotd, gotf;

        checks = 0;
        errors = 0;
        tbl[0]  = '{1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{1'b0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'hF, 32'h20,  32'h11223344, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 4'h5, 32'h20,  32'hAABBCCDD, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 4'hF, 32'h20,  32'h0,        32'h11BB33DD};
        tbl[5]  = '{1'b1, 4'hF, 32'h00,  32'h00000055, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 4'hF, 32'h30,  32'hCAFEF00D, 32'h11BB33DD};
        tbl[7]  = '{1'b0, 4'hF, 32'h30,  32'h0,        32'hCAFEF00D};
        tbl[8]  = '{1'b1, 4'hF, 32'h47,  32'hA5A5A5A5, 32'hCAFEF00D};
        tbl[9]  = '{1'b0, 4'hF, 32'h44,  32'h0,        32'hA5A5A5A5};
        tbl[10] = '{1'b0, 4'hF, 32'h410, 32'h0,        32'hDEADBEEF};

        reset = 1'b0;
        ua.if_req = 1'b1; ua.if_addr = 32'h0;
        ua.d_req = 1'b1; ua.d_we = 1'b1; ua.d_be = 4'hF; ua.d_addr = 32'h50; ua.d_wdata = 32'h01020304;
        ub.if_req = 1'b0; ub.if_addr = 32'h0;
        ub.d_req = 1'b0; ub.d_we = 1'b0; ub.d_be = 4'h0; ub.d_addr = 32'h0; ub.d_wdata = 32'h0;

        // Reset state with both requests already presented.
        repeat (2) @(negedge clk);
        chk("rst_d_gnt",     32'(ua.d_gnt),     32'd0);
        chk("rst_if_gnt",    32'(ua.if_gnt),    32'd0);
        chk("rst_busy",      32'(busy_a),       32'd0);
        chk("rst_d_rvalid",  32'(ua.d_rvalid),  32'd0);
        chk("rst_if_rvalid", 32'(ua.if_rvalid), 32'd0);
        chk("rst_d_rdata",   ua.d_rdata,        32'h0);
        chk("rst_if_rdata",  ua.if_rdata,       32'h0);

        // First grant in the first cycle after release.
        ua.if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("first_grant", 32'(ua.d_gnt), 32'd1);
        @(posedge clk); #1;
        ua.d_req = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            xfer(1'b0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, rd, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end

        // Fetch of 0x400 wraps to word 0.
        xfer(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, rd, lat);
        chk("wrap_fetch_lat", 32'(lat), 32'd2);
        chk("wrap_fetch_rdata", rd, 32'h00000055);

        // Reset during the WAIT cycle of a store aborts it.
        @(posedge clk); #1;
        ua.d_req = 1'b1; ua.d_we = 1'b1; ua.d_be = 4'hF; ua.d_addr = 32'h30; ua.d_wdata = 32'h0BADBEEF;
        @(negedge clk);
        chk("abort_gnt", 32'(ua.d_gnt), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        ua.d_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_d_rdata", ua.d_rdata, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 32'(ua.d_rvalid), 32'd0);
        end

        // Both channels held: data, fetch, data, three cycles apart.
        ua.d_we = 1'b0; ua.d_be = 4'hF; ua.d_addr = 32'h30;
        ua.if_addr = 32'h10;
        ua.d_req = 1'b1; ua.if_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        ng = 0; gotd = 1'b0; gotf = 1'b0;
        gcyc = '{0, 0, 0}; gch = '{1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 40 && ng < 3; c++) begin
            @(negedge clk);
            if (ua.d_gnt && ua.if_gnt) chk("arb_double_grant", 32'd1, 32'd0);
            if (ua.d_gnt || ua.if_gnt) begin
                gch[ng]  = ua.if_gnt;
                gcyc[ng] = c;
                ng++;
            end
            if (ua.d_rvalid && !gotd) begin
                gotd = 1'b1;
                chk("abort_preserved", ua.d_rdata, 32'hCAFEF00D);
            end
            if (ua.if_rvalid && !gotf) begin
                gotf = 1'b1;
                chk("arb_if_rdata", ua.if_rdata, 32'hDEADBEEF);
            end
        end
        @(posedge clk); #1;
        ua.d_req = 1'b0; ua.if_req = 1'b0;
        chk("arb_grants", 32'(ng), 32'd3);
        chk("arb_order0", 32'(gch[0]), 32'd0);
        chk("arb_order1", 32'(gch[1]), 32'd1);
        chk("arb_order2", 32'(gch[2]), 32'd0);
        chk("arb_space01", 32'(gcyc[1] - gcyc[0]), 32'd3);
        chk("arb_space12", 32'(gcyc[2] - gcyc[1]), 32'd3);
        chk("arb_got_d", 32'(gotd), 32'd1);
        chk("arb_got_f", 32'(gotf), 32'd1);
        repeat (4) @(negedge clk);

        // Zero-latency instance: store then load word 2.
        @(posedge clk); #1;
        ub.d_req = 1'b1; ub.d_we = 1'b1; ub.d_be = 4'hF; ub.d_addr = 32'h8; ub.d_wdata = 32'h00000077;
        @(negedge clk);
        chk("l0_st_gnt", 32'(ub.d_gnt), 32'd1);
        chk("l0_st_busyN", 32'(busy_b), 32'd0);
        @(posedge clk); #1;
        ub.d_req = 1'b0;
        @(negedge clk);
        chk("l0_st_rvalid", 32'(ub.d_rvalid), 32'd1);
        chk("l0_st_busyN1", 32'(busy_b), 32'd1);
        @(negedge clk);
        chk("l0_st_rvalid_end", 32'(ub.d_rvalid), 32'd0);
        chk("l0_st_busyN2", 32'(busy_b), 32'd0);

        @(posedge clk); #1;
        ub.d_req = 1'b1; ub.d_we = 1'b0; ub.d_addr = 32'h8;
        @(negedge clk);
        chk("l0_ld_gnt", 32'(ub.d_gnt), 32'd1);
        chk("l0_ld_busyN", 32'(busy_b), 32'd0);
        @(posedge clk); #1;
        ub.d_req = 1'b0;
        @(negedge clk);
        chk("l0_ld_rvalid", 32'(ub.d_rvalid), 32'd1);
        chk("l0_ld_busyN1", 32'(busy_b), 32'd1);
        chk("l0_ld_rdata", ub.d_rdata, 32'h00000077);
        @(negedge clk);
        chk("l0_ld_rvalid_end", 32'(ub.d_rvalid), 32'd0);
        chk("l0_ld_busyN2", 32'(busy_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
